// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_pkg
// Description : Shared constants and types for the common data bus arbiter.
//               Holds the tag/data widths and the Enable/Disable and
//               True/False constants shared by RS, ROB and LSB, plus the
//               source encoding used for the CDB_Src output.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package cdb_arbiter_pkg;

    localparam int   c_data_w  = 32;
    localparam int   c_rob_w   = 4;

    localparam logic c_enable  = 1'b1;
    localparam logic c_disable = 1'b0;
    localparam logic c_true    = 1'b1;
    localparam logic c_false   = 1'b0;

    // Result source; the encoding is exactly what appears on CDB_Src.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

    // The round-robin pointer always moves to the source that lost.
    function automatic src_e f_other_src(input src_e s);
        return (s == SRC_ALU) ? SRC_LSB : SRC_ALU;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_src_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cdb_src_fifo
// Description : Per-source result queue (tag, value) of DEPTH entries.
//               Supports simultaneous push and pop. The caller guarantees
//               that pop only happens when non-empty and push only when
//               not full.
// Ports       : clk, rst              - clock, async active-high reset
//               clr                   - synchronous flush
//               push, push_tag/value  - append one entry
//               pop                   - drop the head entry
//               head_tag, head_value  - oldest entry (valid when count != 0)
//               count                 - occupancy 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_src_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter  int DATA_W = c_data_w,
    parameter  int ROB_W  = c_rob_w,
    parameter  int DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [ROB_W-1:0]  push_tag,
    input  logic [DATA_W-1:0] push_value,
    input  logic              pop,
    output logic [ROB_W-1:0]  head_tag,
    output logic [DATA_W-1:0] head_value,
    output logic [CNT_W-1:0]  count
);

    logic [ROB_W-1:0]  r_tag   [DEPTH];
    logic [DATA_W-1:0] r_value [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    // Pointer wrap modulo DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= f_next(r_wr_ptr);
            if (pop)  r_rd_ptr <= f_next(r_rd_ptr);
            unique case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Payload storage needs no reset: occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            r_tag[r_wr_ptr]   <= push_tag;
            r_value[r_wr_ptr] <= push_value;
        end
    end

    assign head_tag   = r_tag[r_rd_ptr];
    assign head_value = r_value[r_rd_ptr];
    assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Common data bus arbiter. Each of the ALU and LSB result
//               sources owns a small queue; a round-robin grant picks one
//               candidate per enabled cycle and broadcasts it on registered
//               CDB outputs. An empty queue lets an incoming result bypass
//               straight to arbitration.
// Ports       : clk, rst                      - clock, async active-high reset
//               rdy                           - global enable (low = freeze)
//               clr                           - synchronous flush
//               ALU_S/Reorder/Value, ALU_full - ALU result in, backpressure out
//               LSB_S/Reorder/Value, LSB_full - LSB result in, backpressure out
//               CDB_S/Reorder/Value/Src       - registered broadcast
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter  int DATA_W = c_data_w,
    parameter  int ROB_W  = c_rob_w,
    parameter  int DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              ALU_S,
    input  logic [ROB_W-1:0]  ALU_Reorder,
    input  logic [DATA_W-1:0] ALU_Value,
    output logic              ALU_full,
    input  logic              LSB_S,
    input  logic [ROB_W-1:0]  LSB_Reorder,
    input  logic [DATA_W-1:0] LSB_Value,
    output logic              LSB_full,
    output logic              CDB_S,
    output logic [ROB_W-1:0]  CDB_Reorder,
    output logic [DATA_W-1:0] CDB_Value,
    output logic              CDB_Src
);

    logic              w_en;
    logic [CNT_W-1:0]  w_alu_cnt,  w_lsb_cnt;
    logic [ROB_W-1:0]  w_alu_head_tag, w_lsb_head_tag;
    logic [DATA_W-1:0] w_alu_head_val, w_lsb_head_val;
    logic              w_alu_has,  w_lsb_has;
    logic              w_alu_room, w_lsb_room;
    logic              w_alu_cand, w_lsb_cand;
    logic [ROB_W-1:0]  w_alu_ctag, w_lsb_ctag;
    logic [DATA_W-1:0] w_alu_cval, w_lsb_cval;
    logic              w_gnt_alu,  w_gnt_lsb;
    logic              w_alu_push, w_alu_pop;
    logic              w_lsb_push, w_lsb_pop;

    src_e              r_rr;
    logic              r_cdb_s;
    logic [ROB_W-1:0]  r_cdb_tag;
    logic [DATA_W-1:0] r_cdb_val;
    logic              r_cdb_src;

    // Queue state only moves on an enabled, non-flushing cycle.
    assign w_en = rdy && !clr;

    assign w_alu_has  = (w_alu_cnt != '0);
    assign w_lsb_has  = (w_lsb_cnt != '0);
    assign w_alu_room = (w_alu_cnt != CNT_W'(DEPTH));
    assign w_lsb_room = (w_lsb_cnt != CNT_W'(DEPTH));

    // Candidate: queue head if any, else the incoming result (bypass).
    assign w_alu_cand = w_alu_has || ALU_S;
    assign w_lsb_cand = w_lsb_has || LSB_S;
    assign w_alu_ctag = w_alu_has ? w_alu_head_tag : ALU_Reorder;
    assign w_alu_cval = w_alu_has ? w_alu_head_val : ALU_Value;
    assign w_lsb_ctag = w_lsb_has ? w_lsb_head_tag : LSB_Reorder;
    assign w_lsb_cval = w_lsb_has ? w_lsb_head_val : LSB_Value;

    assign w_gnt_alu = w_alu_cand && (!w_lsb_cand || (r_rr == SRC_ALU));
    assign w_gnt_lsb = w_lsb_cand && !w_gnt_alu;

    // A granted head is popped. An incoming result is queued unless it was
    // itself the bypassed winner, or the queue is already full, in which
    // case the input is a protocol violation and is dropped.
    assign w_alu_pop  = w_en && w_gnt_alu && w_alu_has;
    assign w_lsb_pop  = w_en && w_gnt_lsb && w_lsb_has;
    assign w_alu_push = w_en && ALU_S && w_alu_room && !(w_gnt_alu && !w_alu_has);
    assign w_lsb_push = w_en && LSB_S && w_lsb_room && !(w_gnt_lsb && !w_lsb_has);

    // One slot of headroom covers a result already in flight from issue.
    assign ALU_full = (w_alu_cnt >= CNT_W'(DEPTH - 1));
    assign LSB_full = (w_lsb_cnt >= CNT_W'(DEPTH - 1));

    cdb_src_fifo #(
        .DATA_W     (DATA_W),
        .ROB_W      (ROB_W),
        .DEPTH      (DEPTH)
    ) u_alu_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .push       (w_alu_push),
        .push_tag   (ALU_Reorder),
        .push_value (ALU_Value),
        .pop        (w_alu_pop),
        .head_tag   (w_alu_head_tag),
        .head_value (w_alu_head_val),
        .count      (w_alu_cnt)
    );

    cdb_src_fifo #(
        .DATA_W     (DATA_W),
        .ROB_W      (ROB_W),
        .DEPTH      (DEPTH)
    ) u_lsb_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .push       (w_lsb_push),
        .push_tag   (LSB_Reorder),
        .push_value (LSB_Value),
        .pop        (w_lsb_pop),
        .head_tag   (w_lsb_head_tag),
        .head_value (w_lsb_head_val),
        .count      (w_lsb_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr      <= SRC_ALU;
            r_cdb_s   <= c_false;
            r_cdb_tag <= '0;
            r_cdb_val <= '0;
            r_cdb_src <= SRC_ALU;
        end else if (clr) begin
            r_rr      <= SRC_ALU;
            r_cdb_s   <= c_false;
        end else if (rdy) begin
            if (w_gnt_alu || w_gnt_lsb) begin
                r_cdb_s   <= c_true;
                r_cdb_tag <= w_gnt_lsb ? w_lsb_ctag : w_alu_ctag;
                r_cdb_val <= w_gnt_lsb ? w_lsb_cval : w_alu_cval;
                r_cdb_src <= w_gnt_lsb ? SRC_LSB : SRC_ALU;
                r_rr      <= f_other_src(w_gnt_lsb ? SRC_LSB : SRC_ALU);
            end else begin
                // Tag/value/src hold so downstream sees a stable bus.
                r_cdb_s   <= c_false;
            end
        end
    end

    assign CDB_S       = r_cdb_s;
    assign CDB_Reorder = r_cdb_tag;
    assign CDB_Value   = r_cdb_val;
    assign CDB_Src     = r_cdb_src;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Directed self-checking bench for cdb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    localparam int DATA_W = 32;
    localparam int ROB_W  = 4;
    localparam int DEPTH  = 2;

    logic              clk;
    logic              rst;
    logic              rdy;
    logic              clr;
    logic              ALU_S;
    logic [ROB_W-1:0]  ALU_Reorder;
    logic [DATA_W-1:0] ALU_Value;
    logic              ALU_full;
    logic              LSB_S;
    logic [ROB_W-1:0]  LSB_Reorder;
    logic [DATA_W-1:0] LSB_Value;
    logic              LSB_full;
    logic              CDB_S;
    logic [ROB_W-1:0]  CDB_Reorder;
    logic [DATA_W-1:0] CDB_Value;
    logic              CDB_Src;

    int n_cmp  = 0;
    int n_fail = 0;

    // One table row: stimulus for a cycle, then the bus/full state
    // expected just after the edge that consumes it.
    typedef struct packed {
        logic       as;
        logic [3:0] at;
        logic       ls;
        logic [3:0] lt;
        logic       rdy;
        logic       clr;
        logic       es;
        logic [3:0] et;
        logic       esrc;
        logic       eaf;
        logic       elf;
    } vec_t;

    cdb_arbiter #(
        .DATA_W      (DATA_W),
        .ROB_W       (ROB_W),
        .DEPTH       (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .clr         (clr),
        .ALU_S       (ALU_S),
        .ALU_Reorder (ALU_Reorder),
        .ALU_Value   (ALU_Value),
        .ALU_full    (ALU_full),
        .LSB_S       (LSB_S),
        .LSB_Reorder (LSB_Reorder),
        .LSB_Value   (LSB_Value),
        .LSB_full    (LSB_full),
        .CDB_S       (CDB_S),
        .CDB_Reorder (CDB_Reorder),
        .CDB_Value   (CDB_Value),
        .CDB_Src     (CDB_Src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Column order: alu_s, alu_tag, lsb_s, lsb_tag, rdy, clr,
    //               exp_s, exp_tag, exp_src, exp_alu_full, exp_lsb_full
    function automatic vec_t vec(input logic as, input logic [3:0] at,
                                 input logic ls, input logic [3:0] lt,
                                 input logic rd, input logic cl,
                                 input logic es, input logic [3:0] et,
                                 input logic esrc, input logic eaf,
                                 input logic elf);
        vec_t v;
        v.as = as;  v.at = at;  v.ls = ls;  v.lt = lt;
        v.rdy = rd; v.clr = cl;
        v.es = es;  v.et = et;  v.esrc = esrc;
        v.eaf = eaf; v.elf = elf;
        return v;
    endfunction

    // Values are derived from source and tag so a wrong pairing shows up.
    function automatic logic [31:0] val_of(input logic src, input logic [3:0] tag);
        return src ? (32'hB000_0000 | {28'h0, tag}) : (32'hA000_0000 | {28'h0, tag});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; clr = 1'b0;
        ALU_S = 1'b0; ALU_Reorder = '0; ALU_Value = '0;
        LSB_S = 1'b0; LSB_Reorder = '0; LSB_Value = '0;
    endtask

    task automatic drive(input vec_t v);
        rdy = v.rdy; clr = v.clr;
        ALU_S = v.as; ALU_Reorder = v.at; ALU_Value = val_of(1'b0, v.at);
        LSB_S = v.ls; LSB_Reorder = v.lt; LSB_Value = val_of(1'b1, v.lt);
        step();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #3;
        n_cmp++;
        if ({CDB_S, CDB_Reorder, CDB_Value, CDB_Src, ALU_full, LSB_full} !== 40'h0) begin
            n_fail++;
            $display("FAIL reset: got S=%0b tag=%0d val=%h src=%0b af=%0b lf=%0b, want all zero",
                     CDB_S, CDB_Reorder, CDB_Value, CDB_Src, ALU_full, LSB_full);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        ALU_S = 1'b1; ALU_Reorder = 4'd3; ALU_Value = 32'h11;
        step();
        idle_inputs();
        n_cmp++;
        if ({CDB_S, CDB_Reorder, CDB_Value, CDB_Src} !== {1'b1, 4'd3, 32'h11, 1'b0}) begin
            n_fail++;
            $display("FAIL single_bypass: got S=%0b tag=%0d val=%h src=%0b, want S=1 tag=3 val=11 src=0",
                     CDB_S, CDB_Reorder, CDB_Value, CDB_Src);
        end
        step();
        n_cmp++;
        if ({CDB_S, CDB_Reorder, CDB_Value, ALU_full} !== {1'b0, 4'd3, 32'h11, 1'b0}) begin
            n_fail++;
            $display("FAIL single_idle_hold: got S=%0b tag=%0d val=%h af=%0b, want S=0 tag=3 val=11 af=0",
                     CDB_S, CDB_Reorder, CDB_Value, ALU_full);
        end
    endtask

    task automatic test_both();
        do_reset();
        ALU_S = 1'b1; ALU_Reorder = 4'd1; ALU_Value = 32'hA;
        LSB_S = 1'b1; LSB_Reorder = 4'd2; LSB_Value = 32'hB;
        step();
        idle_inputs();
        n_cmp++;
        if ({CDB_S, CDB_Reorder, CDB_Value, CDB_Src, ALU_full, LSB_full} !==
            {1'b1, 4'd1, 32'hA, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL both_first: got S=%0b tag=%0d val=%h src=%0b af=%0b lf=%0b, want 1 1 a 0 0 1",
                     CDB_S, CDB_Reorder, CDB_Value, CDB_Src, ALU_full, LSB_full);
        end
        step();
        n_cmp++;
        if ({CDB_S, CDB_Reorder, CDB_Value, CDB_Src, LSB_full} !== {1'b1, 4'd2, 32'hB, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL both_second: got S=%0b tag=%0d val=%h src=%0b lf=%0b, want 1 2 b 1 0",
                     CDB_S, CDB_Reorder, CDB_Value, CDB_Src, LSB_full);
        end
        // rr must now point back at the ALU.
        ALU_S = 1'b1; ALU_Reorder = 4'd4; ALU_Value = 32'h4;
        LSB_S = 1'b1; LSB_Reorder = 4'd5; LSB_Value = 32'h5;
        step();
        idle_inputs();
        n_cmp++;
        if ({CDB_S, CDB_Reorder, CDB_Src} !== {1'b1, 4'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL both_rr_back_to_alu: got S=%0b tag=%0d src=%0b, want S=1 tag=4 src=0",
                     CDB_S, CDB_Reorder, CDB_Src);
        end
        step();
        n_cmp++;
        if ({CDB_S, CDB_Reorder, CDB_Value, CDB_Src} !== {1'b1, 4'd5, 32'h5, 1'b1}) begin
            n_fail++;
            $display("FAIL both_drain_lsb: got S=%0b tag=%0d val=%h src=%0b, want 1 5 5 1",
                     CDB_S, CDB_Reorder, CDB_Value, CDB_Src);
        end
        step();
        n_cmp++;
        if (CDB_S !== 1'b0) begin
            n_fail++;
            $display("FAIL both_idle: got S=%0b, want S=0", CDB_S);
        end
    endtask

    task automatic test_stream();
        vec_t q[$];
        logic bad;
        do_reset();
        q.push_back(vec(1, 1, 1, 2, 1, 0,  1, 1, 0, 0, 1));
        q.push_back(vec(1, 3, 1, 4, 1, 0,  1, 2, 1, 1, 1));
        q.push_back(vec(1, 5, 1, 6, 1, 0,  1, 3, 0, 1, 1));
        q.push_back(vec(0, 0, 0, 0, 1, 0,  1, 4, 1, 1, 1));
        q.push_back(vec(0, 0, 0, 0, 1, 0,  1, 5, 0, 0, 1));
        q.push_back(vec(0, 0, 0, 0, 1, 0,  1, 6, 1, 0, 0));
        q.push_back(vec(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));
        foreach (q[i]) begin
            drive(q[i]);
            n_cmp++;
            if (q[i].es)
                bad = {CDB_S, CDB_Reorder, CDB_Value, CDB_Src, ALU_full, LSB_full} !==
                      {1'b1, q[i].et, val_of(q[i].esrc, q[i].et), q[i].esrc, q[i].eaf, q[i].elf};
            else
                bad = {CDB_S, ALU_full, LSB_full} !== {1'b0, q[i].eaf, q[i].elf};
            if (bad) begin
                n_fail++;
                $display("FAIL stream step %0d: got S=%0b tag=%0d val=%h src=%0b af=%0b lf=%0b, want S=%0b tag=%0d src=%0b af=%0b lf=%0b",
                         i, CDB_S, CDB_Reorder, CDB_Value, CDB_Src, ALU_full, LSB_full,
                         q[i].es, q[i].et, q[i].esrc, q[i].eaf, q[i].elf);
            end
        end
        idle_inputs();
    endtask

    task automatic test_clr();
        vec_t q[$];
        logic bad;
        do_reset();
        q.push_back(vec(1, 1, 1, 2, 1, 0,  1, 1, 0, 0, 1));
        q.push_back(vec(1, 3, 1, 4, 1, 0,  1, 2, 1, 1, 1));
        q.push_back(vec(0, 0, 1, 6, 1, 0,  1, 3, 0, 0, 1));
        // Flush with rdy low: still acts, and drops both same-cycle inputs.
        q.push_back(vec(1, 10, 1, 9, 0, 1, 0, 0, 0, 0, 0));
        // rr was cleared, so ALU wins the tie.
        q.push_back(vec(1, 7, 1, 8, 1, 0,  1, 7, 0, 0, 1));
        q.push_back(vec(0, 0, 0, 0, 1, 0,  1, 8, 1, 0, 0));
        q.push_back(vec(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));
        foreach (q[i]) begin
            drive(q[i]);
            n_cmp++;
            if (q[i].es)
                bad = {CDB_S, CDB_Reorder, CDB_Value, CDB_Src, ALU_full, LSB_full} !==
                      {1'b1, q[i].et, val_of(q[i].esrc, q[i].et), q[i].esrc, q[i].eaf, q[i].elf};
            else
                bad = {CDB_S, ALU_full, LSB_full} !== {1'b0, q[i].eaf, q[i].elf};
            if (bad) begin
                n_fail++;
                $display("FAIL clr step %0d: got S=%0b tag=%0d val=%h src=%0b af=%0b lf=%0b, want S=%0b tag=%0d src=%0b af=%0b lf=%0b",
                         i, CDB_S, CDB_Reorder, CDB_Value, CDB_Src, ALU_full, LSB_full,
                         q[i].es, q[i].et, q[i].esrc, q[i].eaf, q[i].elf);
            end
        end
        idle_inputs();
    endtask

    task automatic test_rdy_hold();
        vec_t q[$];
        logic bad;
        do_reset();
        q.push_back(vec(1, 1, 1, 7, 1, 0,  1, 1, 0, 0, 1));
        q.push_back(vec(1, 3, 1, 8, 1, 0,  1, 7, 1, 1, 1));
        q.push_back(vec(1, 5, 1, 9, 1, 0,  1, 3, 0, 1, 1));
        // LSB queue holds 8,9; ALU holds 5. Freeze for three cycles.
        q.push_back(vec(1, 12, 1, 13, 0, 0, 1, 3, 0, 1, 1));
        q.push_back(vec(1, 12, 1, 13, 0, 0, 1, 3, 0, 1, 1));
        q.push_back(vec(1, 12, 1, 13, 0, 0, 1, 3, 0, 1, 1));
        // LSB input while its queue is full is dropped.
        q.push_back(vec(0, 0, 1, 15, 1, 0, 1, 8, 1, 1, 1));
        q.push_back(vec(0, 0, 0, 0, 1, 0,  1, 5, 0, 0, 1));
        q.push_back(vec(0, 0, 0, 0, 1, 0,  1, 9, 1, 0, 0));
        q.push_back(vec(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));
        foreach (q[i]) begin
            drive(q[i]);
            n_cmp++;
            if (q[i].es)
                bad = {CDB_S, CDB_Reorder, CDB_Value, CDB_Src, ALU_full, LSB_full} !==
                      {1'b1, q[i].et, val_of(q[i].esrc, q[i].et), q[i].esrc, q[i].eaf, q[i].elf};
            else
                bad = {CDB_S, ALU_full, LSB_full} !== {1'b0, q[i].eaf, q[i].elf};
            if (bad) begin
                n_fail++;
                $display("FAIL rdy_hold step %0d: got S=%0b tag=%0d val=%h src=%0b af=%0b lf=%0b, want S=%0b tag=%0d src=%0b af=%0b lf=%0b",
                         i, CDB_S, CDB_Reorder, CDB_Value, CDB_Src, ALU_full, LSB_full,
                         q[i].es, q[i].et, q[i].esrc, q[i].eaf, q[i].elf);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(vec(1, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0));
        drive(vec(1, 3, 1, 4, 1, 0, 0, 0, 0, 0, 0));
        idle_inputs();
        n_cmp++;
        if ({CDB_S, CDB_Reorder, ALU_full, LSB_full} !== {1'b1, 4'd2, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got S=%0b tag=%0d af=%0b lf=%0b, want 1 2 1 1",
                     CDB_S, CDB_Reorder, ALU_full, LSB_full);
        end
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({CDB_S, CDB_Reorder, CDB_Value, CDB_Src, ALU_full, LSB_full} !== 40'h0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got S=%0b tag=%0d val=%h src=%0b af=%0b lf=%0b, want all zero",
                     CDB_S, CDB_Reorder, CDB_Value, CDB_Src, ALU_full, LSB_full);
        end
        #2;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if ({CDB_S, ALU_full, LSB_full} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_mid_after %0d: got S=%0b tag=%0d af=%0b lf=%0b, want S=0 af=0 lf=0",
                         k, CDB_S, CDB_Reorder, ALU_full, LSB_full);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_both();
        test_stream();
        test_clr();
        test_rdy_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
